// File: rtl/q_page_out.sv
// Page output queue: buffers {data, eos} tokens with registered flags.
// Optional macro QOUT_LEVEL_EN adds the `level` occupancy port.
module q_page_out #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 65,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] qin_d,
  input  logic             qin_v,
  output logic             qin_b,
  output logic [WIDTH-1:0] qout_d,
  output logic             qout_v,
  input  logic             qout_b
`ifdef QOUT_LEVEL_EN
  ,
  output logic [AW:0]      level
`endif
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             push;
  logic             pop;
  logic             bypass;

  assign push = qin_v & ~qin_b;
  assign pop  = qout_v & ~qout_b;

  assign rd_ptr_next = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign count_next  = count + (AW+1)'(push) - (AW+1)'(pop);

  // New token becomes head directly when nothing older will remain.
  assign bypass = push &
                  ((count == '0) | ((count == ONE) & pop));

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= qin_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      qin_b  <= 1'b0;
      qout_v <= 1'b0;
      qout_d <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      qin_b  <= (count_next == FULL);
      qout_v <= (count_next != '0);
      if (bypass)
        qout_d <= qin_d;
      else if (pop && (count_next != '0))
        qout_d <= mem[rd_ptr_next];
    end
  end

`ifdef QOUT_LEVEL_EN
  assign level = count;
`endif

endmodule
